// File: rtl/cp0_exc.sv
// Coprocessor-0 exception/interrupt block: SR, CAUSE, EPC and PRID, hardware
// interrupt synchronisation, interrupt request generation and mfc0/mtc0 access.
module cp0_exc #(
  parameter logic [31:0] PRID_VAL = 32'h4A57_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  hwint,
  input  logic [29:0] pc,
  input  logic [31:0] din,
  input  logic [4:0]  sel,
  input  logic        we,
  input  logic        exl_set,
  input  logic [4:0]  exccode,
  input  logic        exl_clr,
  output logic        intreq,
  output logic [29:0] epc,
  output logic [31:0] dout
);

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  logic [5:0]  s1;
  logic [5:0]  ip;
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [4:0]  exc_code;
  logic [29:0] epc_q;

  logic wr_sr;
  logic wr_epc;

  assign wr_sr  = we && (sel == SEL_SR);
  assign wr_epc = we && (sel == SEL_EPC);

  // IP follows the second synchroniser stage every cycle; devices clear their own lines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= '0;
      ip <= '0;
    end else begin
      s1 <= hwint;
      ip <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im <= '0;
      ie <= 1'b0;
    end else if (wr_sr) begin
      im <= din[15:10];
      ie <= din[0];
    end
  end

  // EXL priority: exception entry, then eret, then an mtc0 to SR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exl <= 1'b0;
    end else if (exl_set) begin
      exl <= 1'b1;
    end else if (exl_clr) begin
      exl <= 1'b0;
    end else if (wr_sr) begin
      exl <= din[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      epc_q    <= '0;
      exc_code <= '0;
    end else if (exl_set) begin
      epc_q    <= pc;
      exc_code <= exccode;
    end else if (wr_epc) begin
      epc_q    <= din[31:2];
    end
  end

  assign intreq = (|(ip & im)) & ie & ~exl;
  assign epc    = epc_q;

  always_comb begin
    dout = '0;
    case (sel)
      SEL_SR:    dout = {16'h0000, im, 8'h00, exl, ie};
      SEL_CAUSE: dout = {16'h0000, ip, 3'b000, exc_code, 2'b00};
      SEL_EPC:   dout = {epc_q, 2'b00};
      SEL_PRID:  dout = PRID_VAL;
      default:   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc.sv
// Self-checking bench for cp0_exc: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_cp0_exc;

  localparam logic [31:0] PRID = 32'h4A57_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  hwint;
  logic [29:0] pc;
  logic [31:0] din;
  logic [4:0]  sel;
  logic        we;
  logic        exl_set;
  logic [4:0]  exccode;
  logic        exl_clr;
  logic        intreq;
  logic [29:0] epc;
  logic [31:0] dout;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state kept as software-visible register images.
  logic [31:0] m_sr;
  logic [5:0]  m_s1;
  logic [5:0]  m_ip;
  logic [4:0]  m_code;
  logic [29:0] m_epc;

  cp0_exc #(.PRID_VAL(PRID)) dut (
    .clk(clk), .rst(rst), .hwint(hwint), .pc(pc), .din(din), .sel(sel),
    .we(we), .exl_set(exl_set), .exccode(exccode), .exl_clr(exl_clr),
    .intreq(intreq), .epc(epc), .dout(dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return m_sr;
      5'd13:   return {16'h0000, m_ip, 3'b000, m_code, 2'b00};
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return ((m_ip & m_sr[15:10]) != 6'b0) && m_sr[0] && !m_sr[1];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sr = 32'h0; m_s1 = 6'h0; m_ip = 6'h0; m_code = 5'h0; m_epc = 30'h0;
  endtask

  task automatic model_edge();
    if (we && sel == 5'd12) m_sr = din & 32'h0000_FC03;
    if (we && sel == 5'd14) m_epc = din[31:2];
    if (exl_clr) m_sr[1] = 1'b0;
    if (exl_set) begin
      m_sr[1] = 1'b1;
      m_epc   = pc;
      m_code  = exccode;
    end
    m_ip = m_s1;
    m_s1 = hwint;
  endtask

  // Inputs are applied at the falling edge; compare, then clock the model.
  task automatic cyc();
    #1;
    chk("intreq", {31'b0, intreq}, {31'b0, m_int()});
    chk("epc", {2'b00, epc}, {2'b00, m_epc});
    chk("dout", dout, m_read(sel));
    @(posedge clk);
    model_edge();
    @(negedge clk);
    we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0;
  endtask

  task automatic do_reset(input bit pin);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_intreq", {31'b0, intreq}, 32'h0);
    chk("rst_epc", {2'b00, epc}, 32'h0);
    if (pin) begin
      sel = 5'd15; #1 chk("rst_prid", dout, 32'h4A57_0001);
      sel = 5'd12; #1 chk("rst_sr", dout, 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b1; hwint = '0; pc = '0; din = '0; sel = '0;
    we = 1'b0; exl_set = 1'b0; exccode = '0; exl_clr = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset(1'b1);

    // Masked interrupt on line 2
    sel = 5'd12; din = 32'h0000_0401; we = 1'b1; cyc();
    hwint = 6'b000001; cyc();
    chk("int_lat1", {31'b0, intreq}, 32'h0);
    cyc();
    chk("int_lat2", {31'b0, intreq}, 32'h1);
    sel = 5'd13; #1 chk("cause_ip2", dout, 32'h0000_0400);

    // Line 3 is masked off
    hwint = 6'b000000; cyc(); cyc();
    hwint = 6'b000010; cyc(); cyc(); cyc();
    chk("masked_ip3", {31'b0, intreq}, 32'h0);

    // Take and return
    hwint = 6'b000001; cyc(); cyc();
    chk("pre_take", {31'b0, intreq}, 32'h1);
    pc = 30'h0000_0C04; exccode = 5'd0; exl_set = 1'b1; cyc();
    chk("take_intreq", {31'b0, intreq}, 32'h0);
    chk("take_epc", {2'b00, epc}, 32'h0000_0C04);
    sel = 5'd12; #1 chk("take_sr", dout, 32'h0000_0403);
    exl_clr = 1'b1; cyc();
    chk("eret_sr", dout, 32'h0000_0401);
    chk("eret_intreq", {31'b0, intreq}, 32'h1);

    // Priority
    sel = 5'd14; din = 32'h1234_5678; we = 1'b1; pc = 30'h3; exl_set = 1'b1; cyc();
    chk("prio_epc", {2'b00, epc}, 32'h3);
    exl_set = 1'b1; exl_clr = 1'b1; sel = 5'd12; cyc();
    chk("prio_exl", dout, 32'h0000_0403);

    // Illegal accesses
    sel = 5'd13; din = 32'hFFFF_FFFF; we = 1'b1; cyc();
    chk("cause_ro", dout, 32'h0000_0400);
    sel = 5'd5; we = 1'b1; cyc();
    chk("sel5_read", dout, 32'h0);
    sel = 5'd12; #1 chk("sel5_sr", dout, 32'h0000_0403);
    sel = 5'd14; #1 chk("sel5_epc", dout, 32'h0000_000C);
    sel = 5'd15; #1 chk("sel5_prid", dout, 32'h4A57_0001);

    // Randomized traffic
    for (int unsigned i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset(1'b0);
      if ($urandom_range(0, 3) == 0) hwint = 6'($urandom);
      pc      = 30'($urandom);
      exccode = 5'($urandom);
      din     = $urandom;
      sel     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      we      = ($urandom_range(0, 3) == 0);
      exl_set = ($urandom_range(0, 9) == 0);
      exl_clr = ($urandom_range(0, 5) == 0);
      if (we && sel == 5'd12 && $urandom_range(0, 1) == 1) din[1:0] = 2'b01;
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cp0_exc.md
# cp0_exc

Coprocessor-0 exception/interrupt block for the pipelined MIPS core with device support. Holds SR, CAUSE, EPC and PRID, synchronises the six hardware interrupt lines, raises the interrupt request to the pipeline controller, and supplies the return address that feeds the next-PC select mux on `eret`. Serves `mfc0`/`mtc0` at the commit stage.

## Interface
Parameters:
- `PRID_VAL`, 32'h4A57_0001: constant value returned for PRID (CP0 reg 15).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `hwint`  in  6  device interrupt lines [7:2], asynchronous to the pipeline, level-sensitive.
- `pc`  in  30  word PC [31:2] of the instruction at commit.
- `din`  in  32  `mtc0` write data (rt value).
- `sel`  in  5  CP0 register index (rd field) for read and write.
- `we`  in  1  `mtc0` write strobe.
- `exl_set`  in  1  exception/interrupt taken this cycle (from controller).
- `exccode`  in  5  cause code latched with `exl_set` (0 = interrupt).
- `exl_clr`  in  1  `eret` committing this cycle.
- `intreq`  out  1  interrupt request to controller.
- `epc`  out  30  EPC [31:2], to the next-PC mux `eret` input.
- `dout`  out  32  `mfc0` read data.

## Operation
- SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0, writes ignored.
- CAUSE (13): IP[15:10] (read-only, hardware-driven), ExcCode[6:2]; others read 0. `mtc0` to CAUSE is ignored.
- EPC (14): 30-bit register; reads return {epc, 2'b00}.
- PRID (15): reads `PRID_VAL`; writes ignored.
- Any other `sel`: `dout` = 0, writes ignored.
- `hwint` path: two-flop synchroniser `s1` -> IP. IP is rewritten every cycle from `s1`; no latching or edge detection. The device clears its line.
- `intreq` = |(IP & IM) & IE & ~EXL. Combinational from registered state only, glitch-free relative to `clk`.
- `exl_set`: EXL <= 1, EPC <= `pc`, ExcCode <= `exccode`. IM and IE unchanged.
- `exl_clr`: EXL <= 0.
- `we`: SR <= din fields (IM, EXL, IE); EPC <= din[31:2].
- Priority on one edge:
  - `exl_set` over `we` for EPC and EXL.
  - `exl_set` over `exl_clr`: EXL ends at 1.
  - `we` to SR together with `exl_clr`: EXL = 0, IM/IE from `din`.
  - `we` to SR together with `exl_set`: IM/IE from `din`, EXL = 1.
- `dout` is combinational on `sel` and current registers. A same-cycle `mtc0` to the same register is not bypassed; the new value is readable the next cycle.

## Timing
- Reset (`rst` low, asynchronous): SR, CAUSE, EPC, synchroniser flops all 0. Hence `intreq` = 0, `epc` = 0, `dout` = 0 unless `sel` = 15.
- Reset deassertion has no restriction beyond normal recovery. Reset mid-interrupt discards the pending request.
- `hwint` stable high before edge k: `s1` = 1 after k, IP = 1 after k+1. `intreq` is high after k+1 if the mask permits. Latency is 2 edges.
- `exl_set` on edge k: `intreq` is low after edge k (EXL = 1), and `epc` holds the taken `pc` after edge k.
- `exl_clr` on edge k: `intreq` can reassert after edge k if IP & IM is still set.
- `mtc0` on edge k: effect on `intreq` and `dout` is visible after edge k.

## Test plan
- Reset: drive `rst` = 0 mid-cycle -> immediately `intreq` = 0, `epc` = 0; `sel` = 15 reads 32'h4A57_0001; `sel` = 12 reads 0.
- Masked interrupt:
  - write SR = 32'h0000_0401 (IM[2], IE), raise `hwint[2]` -> `intreq` high exactly 2 edges later; CAUSE reads 32'h0000_0400.
  - Raise `hwint[3]` instead -> `intreq` stays 0.
- Take/return:
  - with `intreq` high, pulse `exl_set` with `pc` = 30'h0000_0C04, `exccode` = 0 -> `intreq` low next cycle, `epc` = 30'h0000_0C04, SR reads 32'h0000_0403.
  - Pulse `exl_clr` -> SR = 32'h0000_0401; `intreq` high again while `hwint[2]` held.
- Priority: same edge `we` (`sel` = 14, `din` = 32'h1234_5678) and `exl_set` (`pc` = 30'h3) -> `epc` = 30'h3. Same edge `exl_set` and `exl_clr` -> EXL = 1.
- Illegal accesses:
  - `mtc0` to CAUSE with `din` = 32'hFFFF_FFFF -> CAUSE unchanged.
  - `mtc0` to `sel` = 5 -> no register changes.
  - `sel` = 5 read -> `dout` = 0.
